vote_ctrl: RTL and testbench
============================

Name: vote_ctrl

Overview:
- Ballot-collection controller that sequences the existing 4-input `major` majority block.
- Four voters share a single ballot register through round-robin arbitration. The controller collects one vote per cycle, bounds collection with a timeout, then drives the captured ballot into `major`.
- It returns the registered result over a valid/ready handshake. It sits between voter front-ends and any consumer of the vote outcome.

Parameters:
- TIMEOUT_CYCLES, 16: maximum number of cycles spent in COLLECT; legal range 2..255.
- ABSTAIN_VAL, 1'b0: ballot bit value substituted for any voter that has not voted at timeout.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to open a vote; honoured only in IDLE.
- vote_valid  input  4  per-voter request; bit i = voter i offers a vote.
- vote_val  input  4  per-voter ballot value; bit i sampled when vote_ack[i]=1.
- vote_ack  output  4  one-hot grant, combinational; vote_valid[i]&vote_ack[i] = transfer this cycle.
- busy  output  1  high in COLLECT, EVAL and DONE.
- voted_mask  output  4  registered; bit i set once voter i's vote has been accepted.
- timed_out  output  1  registered; set if COLLECT ended by timeout rather than a full mask.
- result  output  1  registered `major` output for the closed ballot.
- result_valid  output  1  registered; high in DONE.
- result_ready  input  1  consumer accepts result when result_valid&result_ready.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; ballot, voted_mask, timeout counter and rr pointer=0; result, result_valid, timed_out=0; vote_ack=0.
- IDLE, entry:
  - vote_ack=0.
  - start=1: clear ballot, voted_mask, counter and timed_out, then go to COLLECT.
  - result keeps its old value until the next EVAL.
- COLLECT, arbitration:
  - Eligible set = vote_valid & ~voted_mask.
  - Grant goes to the first eligible voter at or after the rr pointer, wrapping 3->0.
  - At most one grant per cycle. On grant i: ballot[i] <= vote_val[i], voted_mask[i] <= 1, rr pointer <= (i+1) mod 4.
  - A voter whose mask bit is already set is never acked again. Repeat vote_valid from that voter is ignored.
- COLLECT, counter: increments every cycle in COLLECT.
- COLLECT, exit:
  - Go to EVAL when the updated voted_mask = 4'b1111, or when counter = TIMEOUT_CYCLES-1.
  - A vote granted in the timeout cycle counts.
  - timed_out <= 1 only if the mask is still incomplete at exit.
  - At exit, ballot bits with mask=0 are forced to ABSTAIN_VAL.
- EVAL: one cycle. The ballot drives `major` {A,B,C,D}={ballot[3],ballot[2],ballot[1],ballot[0]}; result <= Y; go to DONE.
- DONE:
  - result_valid=1 and result is held stable.
  - result_valid&result_ready: go to IDLE and result_valid <= 0.
  - start in DONE is ignored and not queued.
- `major` contract: Y=1 iff at least three of A..D are 1.
- Latency: last vote accepted in cycle N; EVAL in N+1; result_valid high from N+2.
- start outside IDLE: ignored. start and result_ready together in DONE: handshake completes, start is dropped.
- Reset mid-operation: immediate return to IDLE with all reset values. The partial ballot is discarded.

Decomposition:
- Shared package vote_pkg:
  - state enum IDLE/COLLECT/EVAL/DONE.
  - NUM_VOTERS=4 constant.
  - counter width constant (8 bits).
- One sub-module, instantiated as-is: the existing `major`.
- Arbitration stays inline; it is a small priority-from-pointer function.

Test Plan:
- Full ballot, all voters valid in one cycle after start, vote_val=4'b1101:
  - acks one per cycle in order 0,1,2,3.
  - result_valid 2 cycles after the ack[3] cycle.
  - result=1, timed_out=0.
- Fairness: after a round ending at voter 1 (pointer=2), voters 0 and 3 valid together:
  - ack[3] first, then ack[0].
  - Repeat vote_valid[3] is never re-acked.
- Timeout, TIMEOUT_CYCLES=4, only voters 0,1 vote with value 1, ABSTAIN_VAL=0:
  - EVAL after 4 COLLECT cycles; timed_out=1, voted_mask=4'b0011, result=0.
  - With ABSTAIN_VAL=1: result=1.
- Timeout-cycle vote: voter 2 acked on the final COLLECT cycle:
  - voted_mask[2]=1 and ballot[2] is used.
  - timed_out=1 unless the mask is complete.
- Handshake: result_ready=0 for 5 cycles in DONE:
  - result and result_valid held stable.
  - start pulses ignored.
  - result_ready=1 returns to IDLE next cycle.
- Reset in COLLECT with voted_mask=4'b0101: rst_n=0 async gives all outputs 0 and state IDLE. A new start then begins from pointer 0.

Source files
------------

// File: rtl/vote_pkg.sv
// Shared types and sizing constants for the ballot-collection controller.
package vote_pkg;

    localparam int NUM_VOTERS = 4;
    localparam int PTR_W      = $clog2(NUM_VOTERS);
    localparam int CNT_W      = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EVAL    = 2'd2,
        DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/vote_ctrl_major.sv
// Four-input majority: Y is high when at least three of A..D are high.
module major (
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    output logic Y
);

    assign Y = (A & B & C) | (A & B & D) | (A & C & D) | (B & C & D);

endmodule

// File: rtl/vote_ctrl.sv
// Ballot-collection controller: round-robin capture of one vote per cycle with
// a timeout, then a single evaluation cycle through the majority block.
module vote_ctrl
    import vote_pkg::*;
#(
    parameter int   TIMEOUT_CYCLES = 16,
    parameter logic ABSTAIN_VAL    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [NUM_VOTERS-1:0] vote_valid,
    input  logic [NUM_VOTERS-1:0] vote_val,
    output logic [NUM_VOTERS-1:0] vote_ack,
    output logic                  busy,
    output logic [NUM_VOTERS-1:0] voted_mask,
    output logic                  timed_out,
    output logic                  result,
    output logic                  result_valid,
    input  logic                  result_ready
);

    state_e                state_q, state_d;
    logic [NUM_VOTERS-1:0] ballot_q, ballot_d;
    logic [NUM_VOTERS-1:0] voted_mask_q, voted_mask_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [PTR_W-1:0]      rr_q, rr_d;
    logic                  timed_out_q, timed_out_d;
    logic                  result_q, result_d;
    logic                  result_valid_q, result_valid_d;

    logic [NUM_VOTERS-1:0] eligible;
    logic [NUM_VOTERS-1:0] grant;
    logic [PTR_W-1:0]      grant_idx;
    logic [NUM_VOTERS-1:0] mask_upd;
    logic [NUM_VOTERS-1:0] ballot_upd;
    logic                  collect_done;
    logic                  maj_y;

    assign eligible = (state_q == COLLECT) ? (vote_valid & ~voted_mask_q) : '0;

    // Scan from the farthest candidate back toward rr_q so the nearest eligible
    // voter at or after the pointer overwrites earlier picks; wrap relies on
    // NUM_VOTERS being a power of two.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx       = '0;
        grant     = '0;
        grant_idx = '0;
        for (int k = NUM_VOTERS - 1; k >= 0; k--) begin
            idx = rr_q + PTR_W'(k);
            if (eligible[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    assign mask_upd     = voted_mask_q | grant;
    assign ballot_upd   = (ballot_q & ~grant) | (vote_val & grant);
    assign collect_done = (&mask_upd) || (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    major u_major (
        .A (ballot_q[3]),
        .B (ballot_q[2]),
        .C (ballot_q[1]),
        .D (ballot_q[0]),
        .Y (maj_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)        state_d = COLLECT;
            COLLECT: if (collect_done) state_d = EVAL;
            EVAL:                      state_d = DONE;
            DONE:    if (result_ready) state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    always_comb begin
        vote_ack = grant;
        busy     = (state_q != IDLE);
    end

    always_comb begin
        ballot_d       = ballot_q;
        voted_mask_d   = voted_mask_q;
        cnt_d          = cnt_q;
        rr_d           = rr_q;
        timed_out_d    = timed_out_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ballot_d     = '0;
                    voted_mask_d = '0;
                    cnt_d        = '0;
                    timed_out_d  = 1'b0;
                end
            end
            COLLECT: begin
                ballot_d     = ballot_upd;
                voted_mask_d = mask_upd;
                cnt_d        = cnt_q + CNT_W'(1);
                if (|grant) begin
                    rr_d = grant_idx + PTR_W'(1);
                end
                // Voters still missing at close are counted as abstentions.
                if (collect_done) begin
                    timed_out_d = ~(&mask_upd);
                    ballot_d    = (ballot_upd & mask_upd)
                                | ({NUM_VOTERS{ABSTAIN_VAL}} & ~mask_upd);
                end
            end
            EVAL: begin
                result_d       = maj_y;
                result_valid_d = 1'b1;
            end
            DONE: begin
                if (result_ready) begin
                    result_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ballot_q       <= '0;
            voted_mask_q   <= '0;
            cnt_q          <= '0;
            rr_q           <= '0;
            timed_out_q    <= 1'b0;
            result_q       <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            ballot_q       <= ballot_d;
            voted_mask_q   <= voted_mask_d;
            cnt_q          <= cnt_d;
            rr_q           <= rr_d;
            timed_out_q    <= timed_out_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign voted_mask   = voted_mask_q;
    assign timed_out    = timed_out_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_vote_ctrl.sv
// Directed bench for vote_ctrl: two instances differing only in abstain value,
// with expected ballot outcomes queued at stimulus time and checked in DONE.
module tb_vote_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start;
    logic [3:0] vote_valid;
    logic [3:0] vote_val;
    logic       result_ready;

    logic [3:0] ack_a, mask_a, ack_b, mask_b;
    logic       busy_a, to_a, res_a, rv_a;
    logic       busy_b, to_b, res_b, rv_b;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       r0;
        logic       r1;
        logic       to;
        logic [3:0] mask;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    vote_ctrl #(.TIMEOUT_CYCLES(4), .ABSTAIN_VAL(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start),
        .vote_valid(vote_valid), .vote_val(vote_val), .vote_ack(ack_a),
        .busy(busy_a), .voted_mask(mask_a), .timed_out(to_a),
        .result(res_a), .result_valid(rv_a), .result_ready(result_ready)
    );

    vote_ctrl #(.TIMEOUT_CYCLES(4), .ABSTAIN_VAL(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start),
        .vote_valid(vote_valid), .vote_val(vote_val), .vote_ack(ack_b),
        .busy(busy_b), .voted_mask(mask_b), .timed_out(to_b),
        .result(res_b), .result_valid(rv_b), .result_ready(result_ready)
    );

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] ballot_abs0, input logic [3:0] ballot_abs1,
                                input logic to, input logic [3:0] mask);
        exp_t e;
        e.r0   = ($countones(ballot_abs0) >= 3);
        e.r1   = ($countones(ballot_abs1) >= 3);
        e.to   = to;
        e.mask = mask;
        return e;
    endfunction

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s_sb: observed=empty-queue expected=pending-entry", tag);
        end else begin
            e = sb.pop_front();
            chk1({tag, "_res_a"}, res_a, e.r0);
            chk1({tag, "_res_b"}, res_b, e.r1);
            chk1({tag, "_to_a"}, to_a, e.to);
            chk1({tag, "_to_b"}, to_b, e.to);
            chk4({tag, "_mask_a"}, mask_a, e.mask);
            chk4({tag, "_mask_b"}, mask_b, e.mask);
            $display("txn %s: result_a=%b result_b=%b timed_out=%b mask=%b", tag, res_a, res_b, to_a, mask_a);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic s, input logic [3:0] vv, input logic [3:0] vl, input logic rdy);
        start        = s;
        vote_valid   = vv;
        vote_val     = vl;
        result_ready = rdy;
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: observed=no-finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        start = 1'b0; vote_valid = 4'hF; vote_val = 4'h0; result_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk1("rst_busy", busy_a, 1'b0);
        chk4("rst_mask", mask_a, 4'b0000);
        chk4("rst_ack", ack_a, 4'b0000);
        chk1("rst_rv", rv_a, 1'b0);
        chk1("rst_res", res_a, 1'b0);
        chk1("rst_to", to_a, 1'b0);
        rst_n = 1'b1;

        // Full ballot, all voters valid together, value 1101.
        @(negedge clk); drive(1'b1, 4'h0, 4'h0, 1'b0);
        @(negedge clk); drive(1'b0, 4'hF, 4'hD, 1'b0);
        chk1("s1_busy", busy_a, 1'b1);
        chk4("s1_ack0", ack_a, 4'b0001);
        sb.push_back(mk(4'b1101, 4'b1101, 1'b0, 4'b1111));
        @(negedge clk); drive(1'b0, 4'hF, 4'hD, 1'b0);
        chk4("s1_ack1", ack_a, 4'b0010);
        chk4("s1_mask1", mask_a, 4'b0001);
        @(negedge clk); drive(1'b0, 4'hF, 4'hD, 1'b0);
        chk4("s1_ack2", ack_a, 4'b0100);
        chk4("s1_mask2", mask_a, 4'b0011);
        @(negedge clk); drive(1'b0, 4'hF, 4'hD, 1'b0);
        chk4("s1_ack3", ack_a, 4'b1000);
        chk4("s1_mask3", mask_a, 4'b0111);
        @(negedge clk); drive(1'b0, 4'hF, 4'hD, 1'b0);
        chk4("s1_eval_ack", ack_a, 4'b0000);
        chk1("s1_eval_rv", rv_a, 1'b0);
        @(negedge clk); drive(1'b0, 4'h0, 4'h0, 1'b1);
        chk1("s1_done_rv", rv_a, 1'b1);
        pop_check("s1");
        @(negedge clk); drive(1'b0, 4'h0, 4'h0, 1'b0);
        chk1("s1_idle_rv", rv_a, 1'b0);
        chk1("s1_idle_busy", busy_a, 1'b0);
        chk1("s1_idle_res", res_a, 1'b1);

        // Timeout: only voters 0 and 1 vote 1; ends with pointer at 2.
        @(negedge clk); drive(1'b1, 4'h0, 4'h0, 1'b0);
        @(negedge clk); drive(1'b0, 4'b0011, 4'b0011, 1'b0);
        chk4("s2_ack0", ack_a, 4'b0001);
        sb.push_back(mk(4'b0011, 4'b1111, 1'b1, 4'b0011));
        @(negedge clk); drive(1'b0, 4'b0011, 4'b0011, 1'b0);
        chk4("s2_ack1", ack_a, 4'b0010);
        @(negedge clk); drive(1'b0, 4'h0, 4'h0, 1'b0);
        chk4("s2_mask", mask_a, 4'b0011);
        chk1("s2_busy2", busy_a, 1'b1);
        @(negedge clk); drive(1'b0, 4'h0, 4'h0, 1'b0);
        chk1("s2_busy3", busy_a, 1'b1);
        chk1("s2_rv3", rv_a, 1'b0);
        @(negedge clk); drive(1'b0, 4'b1100, 4'b1100, 1'b0);
        chk4("s2_eval_ack", ack_a, 4'b0000);
        chk1("s2_eval_rv", rv_a, 1'b0);
        chk1("s2_eval_to", to_a, 1'b1);
        @(negedge clk); drive(1'b0, 4'h0, 4'h0, 1'b0);
        chk1("s2_done_rv", rv_a, 1'b1);
        pop_check("s2");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); drive(i[0] == 1'b0, 4'h0, 4'h0, 1'b0);
            chk1("s2_hold_rv", rv_a, 1'b1);
            chk1("s2_hold_res_a", res_a, 1'b0);
            chk1("s2_hold_res_b", res_b, 1'b1);
        end
        @(negedge clk); drive(1'b1, 4'h0, 4'h0, 1'b1);
        chk1("s2_hs_rv", rv_a, 1'b1);
        @(negedge clk); drive(1'b0, 4'h0, 4'h0, 1'b0);
        chk1("s2_after_rv", rv_a, 1'b0);
        chk1("s2_after_busy", busy_a, 1'b0);
        @(negedge clk); drive(1'b0, 4'h0, 4'h0, 1'b0);
        chk1("s2_start_dropped", busy_a, 1'b0);

        // Fairness from pointer 2, repeat vote from voter 3, vote in the timeout cycle.
        @(negedge clk); drive(1'b1, 4'h0, 4'h0, 1'b0);
        @(negedge clk); drive(1'b0, 4'b1001, 4'b1001, 1'b0);
        chk4("s3_ack0", ack_a, 4'b1000);
        sb.push_back(mk(4'b1101, 4'b1111, 1'b1, 4'b1101));
        @(negedge clk); drive(1'b0, 4'b1001, 4'b1001, 1'b0);
        chk4("s3_ack1", ack_a, 4'b0001);
        @(negedge clk); drive(1'b0, 4'b1000, 4'b1001, 1'b0);
        chk4("s3_ack_repeat", ack_a, 4'b0000);
        @(negedge clk); drive(1'b0, 4'b1100, 4'b0100, 1'b0);
        chk4("s3_ack_last", ack_a, 4'b0100);
        chk4("s3_mask3", mask_a, 4'b1001);
        @(negedge clk); drive(1'b0, 4'h0, 4'h0, 1'b0);
        chk1("s3_eval_rv", rv_a, 1'b0);
        @(negedge clk); drive(1'b0, 4'h0, 4'h0, 1'b1);
        chk1("s3_done_rv", rv_a, 1'b1);
        pop_check("s3");
        @(negedge clk); drive(1'b0, 4'h0, 4'h0, 1'b0);
        chk1("s3_idle_busy", busy_a, 1'b0);

        // Mask completes on the timeout cycle: no timeout flag.
        @(negedge clk); drive(1'b1, 4'h0, 4'h0, 1'b0);
        @(negedge clk); drive(1'b0, 4'b0111, 4'b1110, 1'b0);
        chk4("s4_ack0", ack_a, 4'b0001);
        sb.push_back(mk(4'b1110, 4'b1110, 1'b0, 4'b1111));
        @(negedge clk); drive(1'b0, 4'b0111, 4'b1110, 1'b0);
        chk4("s4_ack1", ack_a, 4'b0010);
        @(negedge clk); drive(1'b0, 4'b0111, 4'b1110, 1'b0);
        chk4("s4_ack2", ack_a, 4'b0100);
        @(negedge clk); drive(1'b0, 4'b1000, 4'b1110, 1'b0);
        chk4("s4_ack3", ack_a, 4'b1000);
        @(negedge clk); drive(1'b0, 4'h0, 4'h0, 1'b0);
        chk1("s4_eval_rv", rv_a, 1'b0);
        @(negedge clk); drive(1'b0, 4'h0, 4'h0, 1'b1);
        chk1("s4_done_rv", rv_a, 1'b1);
        pop_check("s4");
        @(negedge clk); drive(1'b0, 4'h0, 4'h0, 1'b0);
        chk1("s4_idle_busy", busy_a, 1'b0);

        // Asynchronous reset in COLLECT with mask 0101, then restart from pointer 0.
        @(negedge clk); drive(1'b1, 4'h0, 4'h0, 1'b0);
        @(negedge clk); drive(1'b0, 4'b0101, 4'b0101, 1'b0);
        chk4("s5_ack0", ack_a, 4'b0001);
        @(negedge clk); drive(1'b0, 4'b0101, 4'b0101, 1'b0);
        chk4("s5_ack1", ack_a, 4'b0100);
        @(negedge clk); drive(1'b0, 4'h0, 4'h0, 1'b0);
        chk4("s5_mask", mask_a, 4'b0101);
        vote_valid = 4'hF;
        #2 rst_n = 1'b0;
        #1;
        chk1("s5_rst_busy", busy_a, 1'b0);
        chk4("s5_rst_mask", mask_a, 4'b0000);
        chk4("s5_rst_ack", ack_a, 4'b0000);
        chk1("s5_rst_res", res_a, 1'b0);
        chk1("s5_rst_rv", rv_a, 1'b0);
        chk1("s5_rst_to", to_a, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 4'h0, 4'h0, 1'b0);
        @(negedge clk); drive(1'b0, 4'hF, 4'b0111, 1'b0);
        chk4("s5_new_ack0", ack_a, 4'b0001);
        sb.push_back(mk(4'b0111, 4'b0111, 1'b0, 4'b1111));
        @(negedge clk); drive(1'b0, 4'hF, 4'b0111, 1'b0);
        chk4("s5_new_ack1", ack_a, 4'b0010);
        @(negedge clk); drive(1'b0, 4'hF, 4'b0111, 1'b0);
        chk4("s5_new_ack2", ack_a, 4'b0100);
        @(negedge clk); drive(1'b0, 4'hF, 4'b0111, 1'b0);
        chk4("s5_new_ack3", ack_a, 4'b1000);
        @(negedge clk); drive(1'b0, 4'h0, 4'h0, 1'b0);
        chk1("s5_eval_rv", rv_a, 1'b0);
        @(negedge clk); drive(1'b0, 4'h0, 4'h0, 1'b1);
        chk1("s5_done_rv", rv_a, 1'b1);
        pop_check("s5");
        @(negedge clk); drive(1'b0, 4'h0, 4'h0, 1'b0);
        chk1("s5_idle_busy", busy_a, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
